opl3_sample_pacer: RTL and testbench

- Downstream consumer of the OPL3 sequencer. Sits between the sequencer's ready/rd/A/B handshake and the core audio mixer.
- Generates the 44.1 kHz sample cadence from clk using a fractional accumulator.
- Issues exactly one sequencer read per sample period and captures the stereo result.
- Presents a jitter-free, registered stereo sample with a one-cycle strobe. Detects and counts overruns, when the sequencer has not finished by the next period.

---
 rtl/opl3_pkg.sv | 15 +
 rtl/opl3_rate_gen.sv | 35 +++
 rtl/opl3_sample_pacer.sv | 98 +++++++++
 tb/tb_opl3_sample_pacer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared types and defaults for the OPL3 output sample pacer.
package opl3_pkg;

    typedef logic signed [15:0] opl3_sample_t;

    localparam int unsigned OPL3_CLK_HZ  = 50_000_000;
    localparam int unsigned OPL3_RATE_HZ = 44_100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_READ
    } pacer_state_e;

endpackage

// File: rtl/opl3_rate_gen.sv
// Fractional-accumulator sample tick: exactly RATE_HZ ticks per CLK_HZ clocks.
module opl3_rate_gen
    import opl3_pkg::*;
#(
    parameter int unsigned CLK_HZ  = OPL3_CLK_HZ,
    parameter int unsigned RATE_HZ = OPL3_RATE_HZ
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [31:0] r_phase;
    logic        r_tick;
    logic [32:0] w_sum;

    // One spare bit so phase + RATE_HZ cannot wrap before the compare.
    assign w_sum = {1'b0, r_phase} + 33'(RATE_HZ);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else if (w_sum >= 33'(CLK_HZ)) begin
            r_phase <= 32'(w_sum - 33'(CLK_HZ));
            r_tick  <= 1'b1;
        end else begin
            r_phase <= 32'(w_sum);
            r_tick  <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/opl3_sample_pacer.sv
// Paces one sequencer read per sample period and emits a registered stereo sample.
module opl3_sample_pacer
    import opl3_pkg::*;
#(
    parameter int unsigned CLK_HZ             = OPL3_CLK_HZ,
    parameter int unsigned RATE_HZ            = OPL3_RATE_HZ,
    parameter bit          CHECK_FRAME_BUDGET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mute,
    input  logic        seq_ready,
    input  logic [15:0] seq_a,
    input  logic [15:0] seq_b,
    output logic        seq_rd,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_strobe,
    output logic [7:0]  overrun_cnt
);

    if (RATE_HZ >= CLK_HZ) begin : g_bad_rate
        $error("opl3_sample_pacer: RATE_HZ must be below CLK_HZ");
    end

    // The sequencer needs up to 1024 clocks per frame.
    if (CHECK_FRAME_BUDGET && (CLK_HZ / RATE_HZ) < 1024) begin : g_bad_budget
        $error("opl3_sample_pacer: CLK_HZ/RATE_HZ below sequencer frame budget");
    end

    logic         w_tick;
    pacer_state_e r_state;
    logic         r_seq_rd;
    opl3_sample_t r_buf_l;
    opl3_sample_t r_buf_r;
    logic [15:0]  r_out_l;
    logic [15:0]  r_out_r;
    logic         r_strobe;
    logic [7:0]   r_overrun;

    opl3_rate_gen #(
        .CLK_HZ (CLK_HZ),
        .RATE_HZ(RATE_HZ)
    ) u_rate_gen (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_seq_rd  <= 1'b0;
            r_buf_l   <= '0;
            r_buf_r   <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_strobe  <= 1'b0;
            r_overrun <= '0;
        end else begin
            r_seq_rd <= 1'b0;
            // enable only gates new requests; an open handshake always completes.
            case (r_state)
                S_IDLE: begin
                    if (w_tick && enable) r_state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (seq_ready) begin
                        r_state  <= S_READ;
                        r_seq_rd <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_IDLE;
                    r_buf_l <= seq_a;
                    r_buf_r <= seq_b;
                end
                default: r_state <= S_IDLE;
            endcase

            // Emit reads the buffer before any same-edge capture lands.
            if (w_tick) begin
                r_out_l <= (mute || !enable) ? '0 : r_buf_l;
                r_out_r <= (mute || !enable) ? '0 : r_buf_r;
                if (r_state != S_IDLE && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
            end
            r_strobe <= w_tick;
        end
    end

    assign seq_rd      = r_seq_rd;
    assign out_l       = r_out_l;
    assign out_r       = r_out_r;
    assign out_strobe  = r_strobe;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_opl3_sample_pacer.sv
// Randomized bench for opl3_sample_pacer against a cycle-level behavioural model.
module tb_opl3_sample_pacer;

    localparam int unsigned CA = 441000;
    localparam int unsigned RA = 44100;
    localparam int unsigned CF = 100;
    localparam int unsigned RF = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        mute = 1'b0;
    logic        seq_ready;
    logic [15:0] seq_a, seq_b;
    logic        seq_rd;
    logic [15:0] out_l, out_r;
    logic        out_strobe;
    logic [7:0]  overrun_cnt;

    logic        f_rd, f_strobe;
    logic [15:0] f_out_l, f_out_r;
    logic [7:0]  f_ovr;

    always #5 clk = ~clk;

    opl3_sample_pacer #(.CLK_HZ(CA), .RATE_HZ(RA), .CHECK_FRAME_BUDGET(1'b0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mute(mute),
        .seq_ready(seq_ready), .seq_a(seq_a), .seq_b(seq_b), .seq_rd(seq_rd),
        .out_l(out_l), .out_r(out_r), .out_strobe(out_strobe), .overrun_cnt(overrun_cnt)
    );

    opl3_sample_pacer #(.CLK_HZ(CF), .RATE_HZ(RF), .CHECK_FRAME_BUDGET(1'b0)) u_dut_f (
        .clk(clk), .reset(reset), .enable(1'b1), .mute(1'b0),
        .seq_ready(1'b1), .seq_a(16'h0000), .seq_b(16'h0000), .seq_rd(f_rd),
        .out_l(f_out_l), .out_r(f_out_r), .out_strobe(f_strobe), .overrun_cnt(f_ovr)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // Stub sequencer: ready drops on rd, returns after a delay with the next frame.
    int  stub_delay = 5;
    bit  stub_hold = 1'b0;
    bit  rand_data = 1'b0;
    int  s_frame, s_cnt;
    bit  s_busy;

    always @(negedge clk) begin
        if (reset) begin
            seq_ready = 1'b1; seq_a = '0; seq_b = '0;
            s_frame = 0; s_cnt = 0; s_busy = 1'b0;
        end else if (seq_rd && !s_busy) begin
            seq_ready = 1'b0; s_busy = 1'b1; s_frame++; s_cnt = stub_delay;
        end else if (s_busy) begin
            if (s_cnt > 1) s_cnt--;
            else if (!stub_hold) begin
                s_busy = 1'b0; seq_ready = 1'b1;
                seq_a = rand_data ? 16'($urandom) : 16'(s_frame);
                seq_b = rand_data ? 16'($urandom) : 16'(-s_frame);
            end
        end
    end

    // Behavioural model: tick after edge e iff floor(e*R/C) advances.
    function automatic bit crosses(input longint e, input longint r, input longint c);
        return (e * r) / c != ((e - 1) * r) / c;
    endfunction

    longint      n_edge;
    bit          m_tick, m_tick_f, m_wait, m_rd, m_stb, m_stb_f;
    logic [15:0] m_bl, m_br, m_ol, m_or;
    int          m_cnt;

    always @(posedge clk) begin
        bit busy, nxt_rd, nxt_wait;
        if (reset) begin
            n_edge = 0; m_tick = 0; m_tick_f = 0; m_wait = 0; m_rd = 0;
            m_stb = 0; m_stb_f = 0; m_bl = '0; m_br = '0; m_ol = '0; m_or = '0; m_cnt = 0;
        end else begin
            busy   = m_wait || m_rd;
            nxt_rd = m_wait && seq_ready;
            m_stb   = m_tick;
            m_stb_f = m_tick_f;
            if (m_tick) begin
                m_ol = (mute || !enable) ? 16'h0 : m_bl;
                m_or = (mute || !enable) ? 16'h0 : m_br;
                if (busy && m_cnt < 255) m_cnt++;
            end
            if (m_rd) begin m_bl = seq_a; m_br = seq_b; end
            nxt_wait = nxt_rd ? 1'b0 : (m_wait || (m_tick && enable && !busy));
            m_rd   = nxt_rd;
            m_wait = nxt_wait;
            n_edge++;
            m_tick   = crosses(n_edge, RA, CA);
            m_tick_f = crosses(n_edge, RF, CF);
        end
    end

    always @(posedge clk) begin
        #1;
        check("seq_rd", 32'(seq_rd), 32'(m_rd));
        check("out_strobe", 32'(out_strobe), 32'(m_stb));
        check("out_l", 32'(out_l), 32'(m_ol));
        check("out_r", 32'(out_r), 32'(m_or));
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_cnt));
        check("frac_strobe", 32'(f_strobe), 32'(m_stb_f));
    end

    task automatic wait_model_wait(input string name);
        int k = 0;
        while (!m_wait && k < 100) begin @(negedge clk); k++; end
        if (!m_wait) check(name, 32'(m_wait), 32'd1);
    endtask

    initial begin
        int sa, first_a, rd_cnt, b2b, cf, fi, rd_dis, k;
        int fe[7];
        bit prev_rd;

        repeat (3) @(negedge clk);
        check("rst_out_l", 32'(out_l), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
        check("rst_rd", 32'(seq_rd), 32'd0);
        reset = 1'b0;

        // Cadence, pipeline and fractional spacing.
        sa = 0; first_a = 0; rd_cnt = 0; b2b = 0; cf = 0; fi = 0; prev_rd = 0;
        for (int e = 1; e <= 1010; e++) begin
            @(posedge clk); #2;
            if (out_strobe) begin
                sa++;
                if (sa == 1) first_a = e;
                if (sa == 2) check("pipe2_l", 32'(out_l), 32'd0);
                if (sa == 5) begin
                    check("pipe5_l", 32'(out_l), 32'd3);
                    check("pipe5_r", 32'(out_r), 32'h0000_FFFD);
                end
                if (sa == 12) begin
                    check("pipe12_l", 32'(out_l), 32'd10);
                    check("pipe12_r", 32'(out_r), 32'h0000_FFF6);
                end
            end
            if (seq_rd) rd_cnt++;
            if (seq_rd && prev_rd) b2b++;
            prev_rd = seq_rd;
            if (e >= 101 && e <= 200 && f_strobe) cf++;
            if (f_strobe && fi < 7) begin fe[fi] = e; fi++; end
        end
        check("first_strobe", 32'(first_a), 32'd11);
        check("strobes_1000", 32'(sa), 32'd100);
        check("rd_count", 32'(rd_cnt), 32'd100);
        check("rd_back2back", 32'(b2b), 32'd0);
        check("frac_count", 32'(cf), 32'd30);
        check("frac_first", 32'(fe[0]), 32'd5);
        for (int i = 1; i < 7; i++)
            check("frac_interval", 32'(fe[i] - fe[i-1]), (i % 3 == 0) ? 32'd4 : 32'd3);

        // Random frame latency, data, mute and enable.
        rand_data = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            stub_delay = int'($urandom_range(1, 18));
            if ($urandom_range(0, 49) == 0) mute = ~mute;
            if ($urandom_range(0, 199) == 0) enable = ~enable;
        end
        @(negedge clk);
        mute = 1'b0; enable = 1'b1;

        // Sequencer stuck: every period overruns until the counter saturates.
        stub_hold = 1'b1;
        repeat (3100) @(negedge clk);
        check("ovr_saturate", 32'(overrun_cnt), 32'd255);
        stub_hold = 1'b0; stub_delay = 8;
        repeat (50) @(negedge clk);

        // enable drops mid-handshake: exactly one rd completes, then silence.
        stub_hold = 1'b1;
        repeat (30) @(negedge clk);
        wait_model_wait("wait_timeout_en");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        stub_hold = 1'b0;
        rd_dis = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            if (seq_rd) rd_dis++;
        end
        check("rd_after_disable", 32'(rd_dis), 32'd1);
        check("out_l_disabled", 32'(out_l), 32'd0);

        // Reset mid-handshake.
        @(negedge clk);
        enable = 1'b1; stub_hold = 1'b1;
        repeat (30) @(negedge clk);
        wait_model_wait("wait_timeout_rst");
        reset = 1'b1;
        @(posedge clk); #2;
        check("rst_mid_rd", 32'(seq_rd), 32'd0);
        check("rst_mid_ovr", 32'(overrun_cnt), 32'd0);
        check("rst_mid_out", 32'(out_l), 32'd0);
        @(negedge clk);
        reset = 1'b0; stub_hold = 1'b0;
        k = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #2;
            if (out_strobe && k == 0) k = e;
        end
        check("rst_first_strobe", 32'(k), 32'd11);

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            stub_delay = int'($urandom_range(1, 14));
            if ($urandom_range(0, 29) == 0) mute = ~mute;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
